neuron_mac7: RTL and testbench
==============================

Name: neuron_mac7

Overview:
- Single sequential neuron that serially accumulates N_INPUTS signed 7-bit activation×weight products onto a signed bias.
- Saturates the result to a signed 7-bit value and presents it with a valid/ready handshake.
- Sits directly upstream of the 7-to-1 convertor. The sum_out vector is the 7-bit port the convertor reduces to one bit.

Parameters:
- N_INPUTS, 4, number of x/w pairs accumulated per neuron evaluation (1..255)
- ACC_W, 20, internal signed accumulator width; must be ≥ 14 + clog2(N_INPUTS) + 1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a new evaluation (sampled only in IDLE)
- bias  input  7  signed bias, sampled on the accepted start cycle
- in_valid  input  1  x_in/w_in hold a valid pair
- in_ready  output  1  block accepts a pair this cycle
- x_in  input  7  signed activation
- w_in  input  7  signed weight
- out_valid  output  1  sum_out valid
- out_ready  input  1  consumer takes sum_out
- sum_out  output  7  signed saturated result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at clk edge) sets the following:
  - state=IDLE, acc=0, count=0
  - in_ready=0, out_valid=0, sum_out=7'b0000000, busy=0
- Reset wins over every other input, including mid-ACCUM and mid-DONE. Any partial sum is discarded.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - When start=1: acc ← sign-extended bias, count ← 0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready.
  - On each transfer: acc ← acc + sext(x_in × w_in). The product is a full signed 14-bit value.
  - On each transfer: count ← count+1.
  - On the transfer where count == N_INPUTS-1:
    - sum_out ← sat7(acc + product), where sat7 clamps to [-64, +63].
    - out_valid ← 1, go to DONE.
  - No transfer: acc and count hold; bubbles are allowed indefinitely.
  - start is ignored while in ACCUM.
- DONE:
  - in_ready=0; out_valid=1; sum_out stable.
  - When out_ready=1: out_valid ← 0, go to IDLE next cycle.
  - start during DONE is ignored. A new evaluation needs start in IDLE, so the minimum gap is 1 idle cycle.
- Latency: out_valid rises on the clock edge following the last accepted pair, i.e. 1 cycle.
- Throughput: 1 pair/cycle. A full evaluation takes 1 (start) + N_INPUTS + 1 (handshake) cycles minimum.
- Arithmetic:
  - Two's-complement throughout.
  - acc never wraps for legal ACC_W.
  - Saturation is applied only at output.
  - Boundary products: -64×-64 = +4096; -64×63 = -4032.
- sum_out holds its last value outside DONE. It is only meaningful while out_valid=1.

Test Plan:
- **Reset and idle:** hold rst_n=0 for 2 cycles, then release with start=0 → busy=0, in_ready=0, out_valid=0, sum_out=0 for 5 cycles.
- **Basic sum:** bias=3; pairs (2,5), (-1,4), (3,3), (0,7), in_valid held high → in_ready high for exactly 4 cycles. One cycle after the 4th pair: out_valid=1, sum_out=3+10-4+9+0=18 (7'b0010010).
- **Positive saturation:** bias=0; four pairs (63,63) → sum_out=+63 (7'b0111111).
- **Negative saturation:** bias=-64; four pairs (-64,63) → sum_out=-64 (7'b1000000).
- **Bubbles and backpressure:**
  - in_valid toggles 1,0,0,1,1,0,1 with pairs (1,1) and bias=0 → sum_out=4 only after the 4th accepted pair.
  - out_ready held 0 for 3 cycles → out_valid and sum_out stay stable.
  - out_ready=1 → IDLE the next cycle.
- **Reset mid-ACCUM, and start ignored outside IDLE:**
  - Assert rst_n=0 after 2 pairs → all outputs return to their reset values on the next edge.
  - A new evaluation then matches a fresh computation.
  - start pulses during ACCUM/DONE have no effect on count or result.

Source files
------------

// File: rtl/neuron_mac7.sv
// Sequential neuron: accumulates N_INPUTS signed 7x7 products onto a bias,
// then presents a saturated signed 7-bit result with a valid/ready handshake.
module neuron_mac7 #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bias,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] x_in,
    input  logic [6:0] w_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] sum_out,
    output logic       busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   count_q, count_d;
    logic        [6:0]         sum_q, sum_d;

    logic signed [13:0]        x_ext, w_ext, prod;
    logic signed [ACC_W-1:0]   prod_ext, acc_sum;
    logic        [ACC_W-7:0]   acc_upper;
    logic                      acc_ovf;
    logic        [6:0]         acc_sat;

    // The true product lies in [-4032, 4096], so a 14-bit multiply is exact.
    always_comb begin
        x_ext     = {{7{x_in[6]}}, x_in};
        w_ext     = {{7{w_in[6]}}, w_in};
        prod      = x_ext * w_ext;
        prod_ext  = {{(ACC_W-14){prod[13]}}, prod};
        acc_sum   = acc_q + prod_ext;
        acc_upper = acc_sum[ACC_W-1:6];
        acc_ovf   = !((&acc_upper) || !(|acc_upper));
        if (acc_ovf) begin
            acc_sat = acc_sum[ACC_W-1] ? 7'b1000000 : 7'b0111111;
        end else begin
            acc_sat = acc_sum[6:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {{(ACC_W-7){bias[6]}}, bias};
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = acc_sum;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_IDX) begin
                        sum_d   = acc_sat;
                        count_d = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_neuron_mac7.sv
// Randomised and directed checks of neuron_mac7 against a plain-integer
// model: clamp(bias + sum(x*w)) to [-64, 63].
module tb_neuron_mac7;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] bias;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] x_in;
    logic [6:0] w_in;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] sum_out;
    logic       busy;

    int passCount  = 0;
    int checkCount = 0;
    int xs [N];
    int ws [N];

    neuron_mac7 #(.N_INPUTS(N), .ACC_W(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .w_in     (w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out  (sum_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int modelResult(input int b);
        int total = b;
        for (int i = 0; i < N; i++) total += xs[i] * ws[i];
        if (total > 63) return 63;
        if (total < -64) return -64;
        return total;
    endfunction

    task automatic checkIdle(input string tag, input int expSum);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_sum"}, int'($signed(sum_out)), expSum);
    endtask

    // validMode: 0 = always valid, 1 = pattern 1,0,0,1,1,0,1, 2 = random
    task automatic applyStimulus(input string tag, input int b, input int validMode,
                                 input int holdCycles, input bit noisyStart);
        int expSum;
        int idx;
        int cyc;
        bit [6:0] pattern;
        pattern = 7'b1011001;
        expSum = modelResult(b);
        start = 1'b1;
        bias  = 7'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 200) begin
            checkOutput({tag, "_accum_in_ready"}, int'(in_ready), 1);
            checkOutput({tag, "_accum_out_valid"}, int'(out_valid), 0);
            case (validMode)
                0: in_valid = 1'b1;
                1: in_valid = (cyc < 7) ? pattern[cyc] : 1'b1;
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            x_in  = 7'(xs[idx]);
            w_in  = 7'(ws[idx]);
            start = noisyStart ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            if (in_valid) idx++;
            cyc++;
            @(negedge clk);
        end
        if (idx < N) checkOutput({tag, "_accum_timeout"}, idx, N);
        in_valid = 1'b0;
        for (int k = 0; k <= holdCycles; k++) begin
            checkOutput({tag, "_done_valid"}, int'(out_valid), 1);
            checkOutput({tag, "_done_sum"}, int'($signed(sum_out)), expSum);
            checkOutput({tag, "_done_in_ready"}, int'(in_ready), 0);
            checkOutput({tag, "_done_busy"}, int'(busy), 1);
            out_ready = (k == holdCycles);
            start = noisyStart ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        start     = 1'b0;
        checkIdle({tag, "_after"}, expSum);
    endtask

    task automatic setPairs(input int x, input int w);
        for (int i = 0; i < N; i++) begin
            xs[i] = x;
            ws[i] = w;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bias = '0;
        in_valid = 1'b0;
        x_in = '0;
        w_in = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkIdle("reset", 0);
            @(posedge clk);
            @(negedge clk);
        end

        xs = '{2, -1, 3, 0};
        ws = '{5, 4, 3, 7};
        applyStimulus("basic", 3, 0, 0, 1'b0);

        setPairs(63, 63);
        applyStimulus("pos_sat", 0, 0, 0, 1'b0);

        setPairs(-64, 63);
        applyStimulus("neg_sat", -64, 0, 0, 1'b0);

        setPairs(-64, -64);
        applyStimulus("max_prod", -64, 0, 1, 1'b0);

        setPairs(1, 1);
        applyStimulus("bubbles", 0, 1, 3, 1'b0);

        // Reset in the middle of an evaluation discards the partial sum.
        setPairs(5, 5);
        start = 1'b1;
        bias  = 7'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        x_in = 7'd5;
        w_in = 7'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdle("mid_reset", 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        xs = '{7, -3, 2, 1};
        ws = '{2, 2, -5, 9};
        applyStimulus("post_reset", -2, 0, 0, 1'b1);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = int'($urandom_range(0, 127)) - 64;
                ws[i] = int'($urandom_range(0, 127)) - 64;
            end
            applyStimulus("random", int'($urandom_range(0, 127)) - 64, 2,
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
